// File: rtl/prgrom_loader_pkg.sv
// Shared types and constants for the program ROM loader: FSM states, error codes,
// default frame start byte and the running-checksum helper.
package minisys_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_CSUM    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

    function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/prgrom_loader_if.sv
// Byte-stream input, program memory write port and load status of the ROM loader.
interface prgrom_loader_if #(parameter int ADDR_WIDTH = 14);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  cpu_hold;
    logic                  busy;
    logic                  load_done;
    logic                  load_err;
    logic [1:0]            err_code;

    modport master (
        input  rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, cpu_hold, busy, load_done, load_err, err_code
    );

    modport slave (
        output rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, cpu_hold, busy, load_done, load_err, err_code
    );
endinterface

// File: rtl/prgrom_loader_timer.sv
// Inter-byte idle counter; o_expire flags the cycle whose idle edge makes the count reach TIMEOUT.
module loader_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] FULL = W'(TIMEOUT);

    logic [W-1:0] r_count;

    // Idle-cycle counter, saturating at TIMEOUT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != FULL)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expire = i_enable && (r_count == LAST);
endmodule

// File: rtl/prgrom_loader.sv
// Frame receiver that packs little-endian bytes into 32-bit words for the program ROM
// and holds the CPU in reset until a complete, checksum-verified image is loaded.
module prgrom_loader
    import minisys_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 14,
    parameter logic [7:0] MAGIC      = DEFAULT_MAGIC,
    parameter int         TIMEOUT    = 1000000
) (
    input  logic           clock,
    input  logic           reset,
    prgrom_loader_if.master bus
);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_e                r_state, w_state_nxt;
    err_e                  r_err, w_err_nxt;
    logic [15:0]           r_count, w_count_nxt;
    logic [15:0]           r_word_idx, w_word_idx_nxt;
    logic [1:0]            r_byte_idx, w_byte_idx_nxt;
    logic [23:0]           r_buf, w_buf_nxt;
    logic [7:0]            r_csum, w_csum_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [31:0]           r_wr_data, w_wr_data_nxt;
    logic                  r_cpu_hold, w_cpu_hold_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_load_done, w_load_done_nxt;
    logic                  r_load_err, w_load_err_nxt;
    logic [15:0]           w_len;
    logic                  w_timer_clr, w_timer_en, w_expire;

    assign w_timer_clr = (r_state == IDLE) || bus.rx_valid;
    assign w_timer_en  = !w_timer_clr;

    loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_timer_clr),
        .i_enable (w_timer_en),
        .o_expire (w_expire)
    );

    // Next-state and registered-output computation
    always_comb begin
        w_state_nxt     = r_state;
        w_err_nxt       = r_err;
        w_count_nxt     = r_count;
        w_word_idx_nxt  = r_word_idx;
        w_byte_idx_nxt  = r_byte_idx;
        w_buf_nxt       = r_buf;
        w_csum_nxt      = r_csum;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_cpu_hold_nxt  = r_cpu_hold;
        w_load_done_nxt = 1'b0;
        w_load_err_nxt  = r_load_err;
        w_len           = {bus.rx_data, r_count[7:0]};

        case (r_state)
            IDLE: begin
                if (bus.rx_valid && (bus.rx_data == MAGIC)) begin
                    w_state_nxt    = LEN_LO;
                    w_cpu_hold_nxt = 1'b1;
                    w_load_err_nxt = 1'b0;
                    w_err_nxt      = ERR_NONE;
                    w_csum_nxt     = 8'h00;
                    w_word_idx_nxt = 16'd0;
                    w_byte_idx_nxt = 2'd0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LEN_LO: begin
                if (bus.rx_valid) begin
                    w_count_nxt = {r_count[15:8], bus.rx_data};
                    w_state_nxt = LEN_HI;
                end else begin
                    w_state_nxt = LEN_LO;
                end
            end
            LEN_HI: begin
                if (bus.rx_valid) begin
                    w_count_nxt = w_len;
                    if ({1'b0, w_len} > MAX_WORDS) begin
                        w_state_nxt    = IDLE;
                        w_load_err_nxt = 1'b1;
                        w_err_nxt      = ERR_LEN;
                    end else if (w_len == 16'd0) begin
                        w_state_nxt = CSUM;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end else begin
                    w_state_nxt = LEN_HI;
                end
            end
            DATA: begin
                if (bus.rx_valid) begin
                    w_csum_nxt     = csum_update(r_csum, bus.rx_data);
                    w_byte_idx_nxt = r_byte_idx + 2'd1;
                    case (r_byte_idx)
                        2'd0:    w_buf_nxt[7:0]   = bus.rx_data;
                        2'd1:    w_buf_nxt[15:8]  = bus.rx_data;
                        2'd2:    w_buf_nxt[23:16] = bus.rx_data;
                        default: begin
                            w_wr_en_nxt    = 1'b1;
                            w_wr_addr_nxt  = r_word_idx[ADDR_WIDTH-1:0];
                            w_wr_data_nxt  = {bus.rx_data, r_buf};
                            w_word_idx_nxt = r_word_idx + 16'd1;
                        end
                    endcase
                    // The final word of the image hands over to checksum comparison
                    if ((r_byte_idx == 2'd3) && (r_word_idx == (r_count - 16'd1))) begin
                        w_state_nxt = CSUM;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end else begin
                    w_state_nxt = DATA;
                end
            end
            CSUM: begin
                if (bus.rx_valid) begin
                    w_state_nxt = IDLE;
                    if (bus.rx_data == r_csum) begin
                        w_load_done_nxt = 1'b1;
                        w_cpu_hold_nxt  = 1'b0;
                    end else begin
                        w_load_err_nxt = 1'b1;
                        w_err_nxt      = ERR_CSUM;
                    end
                end else begin
                    w_state_nxt = CSUM;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Expiry only fires on idle cycles, so it never races a byte being consumed
        if (w_expire) begin
            w_state_nxt    = IDLE;
            w_load_err_nxt = 1'b1;
            w_err_nxt      = ERR_TIMEOUT;
        end else begin
            w_load_err_nxt = w_load_err_nxt;
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_err       <= ERR_NONE;
            r_count     <= 16'd0;
            r_word_idx  <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_buf       <= 24'd0;
            r_csum      <= 8'h00;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 32'd0;
            r_cpu_hold  <= 1'b0;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_err       <= w_err_nxt;
            r_count     <= w_count_nxt;
            r_word_idx  <= w_word_idx_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_buf       <= w_buf_nxt;
            r_csum      <= w_csum_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_cpu_hold  <= w_cpu_hold_nxt;
            r_busy      <= w_busy_nxt;
            r_load_done <= w_load_done_nxt;
            r_load_err  <= w_load_err_nxt;
        end
    end

    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.cpu_hold  = r_cpu_hold;
    assign bus.busy      = r_busy;
    assign bus.load_done = r_load_done;
    assign bus.load_err  = r_load_err;
    assign bus.err_code  = r_err;
endmodule

// File: tb/tb_prgrom_loader.sv
// Directed bench for prgrom_loader: good/bad frames, length overflow, timeout,
// noise with zero-length frame, and reset in the middle of a frame.
module tb_prgrom_loader;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    logic [13:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    prgrom_loader_if #(.ADDR_WIDTH(14)) bus ();

    prgrom_loader #(.ADDR_WIDTH(14), .MAGIC(8'hA5), .TIMEOUT(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Write/done monitor sampled mid-cycle
    always @(negedge clock) begin
        if (bus.wr_en) begin
            wr_cnt++;
            wlog_addr.push_back(bus.wr_addr);
            wlog_data.push_back(bus.wr_data);
        end
        if (bus.load_done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [52:0] all_outs();
        return {bus.wr_en, bus.wr_addr, bus.wr_data, bus.cpu_hold, bus.busy,
                bus.load_done, bus.load_err, bus.err_code};
    endfunction

    task automatic test_reset();
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        reset = 1'b0;
        idle_cycles(3);
        checks++;
        if (all_outs() !== 53'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic send_image(input logic [7:0] last, input string tag);
        logic [7:0] fr[12];
        fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        fr[11] = last;
        for (int i = 0; i < 12; i++) begin
            send_byte(fr[i]);
            if (i == 0) begin
                checks++;
                if ({bus.cpu_hold, bus.busy, bus.load_err} !== 3'b110) begin
                    errors++; $display("FAIL %s_magic_hold_busy: got %b want 110", tag, {bus.cpu_hold, bus.busy, bus.load_err});
                end
            end
            if (i == 5) begin
                checks++;
                if (bus.wr_en !== 1'b0) begin
                    errors++; $display("FAIL %s_early_wr: got %b want 0", tag, bus.wr_en);
                end
            end
            if (i == 6) begin
                checks++;
                if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 14'd0, 32'h12345678}) begin
                    errors++; $display("FAIL %s_word0: got en=%b addr=%h data=%h want 1/0/12345678", tag, bus.wr_en, bus.wr_addr, bus.wr_data);
                end
            end
            if (i == 10) begin
                checks++;
                if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 14'd1, 32'hDEADBEEF}) begin
                    errors++; $display("FAIL %s_word1: got en=%b addr=%h data=%h want 1/1/deadbeef", tag, bus.wr_en, bus.wr_addr, bus.wr_data);
                end
            end
        end
    endtask

    task automatic test_good_load(input string tag);
        int w0 = wr_cnt;
        int d0 = done_cnt;
        checks++;
        if (bus.cpu_hold !== 1'b0) begin
            errors++; $display("FAIL %s_hold_before: got %b want 0", tag, bus.cpu_hold);
        end
        send_image(8'h2A, tag);
        checks++;
        if ({bus.load_done, bus.cpu_hold, bus.load_err, bus.err_code, bus.busy} !== 6'b100000) begin
            errors++; $display("FAIL %s_done: got %b want 100000", tag, {bus.load_done, bus.cpu_hold, bus.load_err, bus.err_code, bus.busy});
        end
        idle_cycles(1);
        checks++;
        if (bus.load_done !== 1'b0 || (wr_cnt - w0) != 2 || (done_cnt - d0) != 1) begin
            errors++; $display("FAIL %s_pulses: got done=%b writes=%0d dones=%0d want 0/2/1", tag, bus.load_done, wr_cnt - w0, done_cnt - d0);
        end
        checks++;
        if (wlog_addr[wlog_addr.size()-1] !== 14'd1 || wlog_data[wlog_data.size()-2] !== 32'h12345678) begin
            errors++; $display("FAIL %s_log: got addr=%h data=%h want 1/12345678", tag, wlog_addr[wlog_addr.size()-1], wlog_data[wlog_data.size()-2]);
        end
    endtask

    task automatic test_bad_csum();
        int w0 = wr_cnt;
        int d0 = done_cnt;
        send_image(8'h2B, "badcs");
        idle_cycles(1);
        checks++;
        if ({bus.load_err, bus.err_code, bus.cpu_hold, bus.busy} !== 5'b11010) begin
            errors++; $display("FAIL badcs_status: got %b want 11010", {bus.load_err, bus.err_code, bus.cpu_hold, bus.busy});
        end
        checks++;
        if ((wr_cnt - w0) != 2 || (done_cnt - d0) != 0) begin
            errors++; $display("FAIL badcs_counts: got writes=%0d dones=%0d want 2/0", wr_cnt - w0, done_cnt - d0);
        end
    endtask

    task automatic test_len_overflow();
        int w0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h40);
        checks++;
        if ({bus.load_err, bus.err_code, bus.busy, bus.cpu_hold} !== 5'b10101) begin
            errors++; $display("FAIL len_status: got %b want 10101", {bus.load_err, bus.err_code, bus.busy, bus.cpu_hold});
        end
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        idle_cycles(1);
        checks++;
        if ({bus.busy, bus.err_code} !== 3'b001 || (wr_cnt - w0) != 0) begin
            errors++; $display("FAIL len_ignored: got busy/err=%b writes=%0d want 001/0", {bus.busy, bus.err_code}, wr_cnt - w0);
        end
    endtask

    task automatic test_timeout();
        int w0 = wr_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        idle_cycles(15);
        checks++;
        if ({bus.busy, bus.load_err} !== 2'b10) begin
            errors++; $display("FAIL tmo_before: got %b want 10", {bus.busy, bus.load_err});
        end
        idle_cycles(1);
        checks++;
        if ({bus.load_err, bus.err_code, bus.busy, bus.cpu_hold} !== 5'b11101 || (wr_cnt - w0) != 0) begin
            errors++; $display("FAIL tmo_fire: got %b writes=%0d want 11101/0", {bus.load_err, bus.err_code, bus.busy, bus.cpu_hold}, wr_cnt - w0);
        end
        send_byte(8'hA5);
        checks++;
        if ({bus.load_err, bus.err_code, bus.busy} !== 4'b0001) begin
            errors++; $display("FAIL tmo_clear: got %b want 0001", {bus.load_err, bus.err_code, bus.busy});
        end
        idle_cycles(16);
        checks++;
        if ({bus.load_err, bus.err_code, bus.busy} !== 4'b1110) begin
            errors++; $display("FAIL tmo_lenlo: got %b want 1110", {bus.load_err, bus.err_code, bus.busy});
        end
    endtask

    task automatic test_noise_zero_len();
        int w0 = wr_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL noise_busy: got %b want 0", bus.busy);
        end
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if ({bus.load_done, bus.cpu_hold, bus.load_err, bus.err_code} !== 5'b10000 || (wr_cnt - w0) != 0) begin
            errors++; $display("FAIL zero_len: got %b writes=%0d want 10000/0", {bus.load_done, bus.cpu_hold, bus.load_err, bus.err_code}, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_mid_data();
        int w0;
        logic [7:0] fr[9];
        fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
        for (int i = 0; i < 9; i++) send_byte(fr[i]);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 53'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got %h want 0", all_outs());
        end
        w0 = wr_cnt;
        idle_cycles(3);
        @(negedge clock);
        reset = 1'b1;
        idle_cycles(2);
        checks++;
        if ((wr_cnt - w0) != 0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet: got writes=%0d busy=%b want 0/0", wr_cnt - w0, bus.busy);
        end
        test_good_load("after_rst");
    endtask

    initial begin
        test_reset();
        test_good_load("good");
        test_bad_csum();
        test_len_overflow();
        test_timeout();
        test_noise_zero_len();
        test_reset_mid_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
